// File: rtl/gray_binary_stream.sv
// rtl/gray_binary_stream.sv - streaming Gray-to-binary decoder with single-step checking
// One-deep output register behind a valid/ready handshake; flags how each decoded word moved from the last.
module gray_binary_stream #(
  parameter int WIDTH     = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_gray,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_bin,
  output logic                 out_inc,
  output logic                 out_dec,
  output logic                 out_step_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic             have_prev;
  logic [WIDTH-1:0] prev_bin;
  logic [WIDTH-1:0] dec_bin;
  logic [WIDTH-1:0] step;
  logic             accept;
  logic             step_inc;
  logic             step_dec;
  logic             step_err;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Bit i of the binary value is the XOR of all Gray bits at or above i.
  always_comb begin
    dec_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec_bin[i] = ^(in_gray >> i);
    end
  end

  // Modular difference makes wrap-around (max -> 0, 0 -> max) a legal single step.
  assign step     = dec_bin - prev_bin;
  assign step_inc = have_prev && (step == WIDTH'(1));
  assign step_dec = have_prev && (step == {WIDTH{1'b1}});
  assign step_err = have_prev && !step_inc && !step_dec && (step != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_bin      <= '0;
      out_inc      <= 1'b0;
      out_dec      <= 1'b0;
      out_step_err <= 1'b0;
      err_count    <= '0;
      have_prev    <= 1'b0;
      prev_bin     <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_bin      <= dec_bin;
      out_inc      <= step_inc;
      out_dec      <= step_dec;
      out_step_err <= step_err;
      have_prev    <= 1'b1;
      prev_bin     <= dec_bin;
      if (step_err && (err_count != {ERR_CNT_W{1'b1}})) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_binary_stream.sv
// tb/tb_gray_binary_stream.sv - scoreboard bench for gray_binary_stream (WIDTH=3, ERR_CNT_W=8)
module tb_gray_binary_stream;

  localparam int WIDTH = 3;
  localparam int ERR_CNT_W = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_gray = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [WIDTH-1:0]     out_bin;
  logic                 out_inc;
  logic                 out_dec;
  logic                 out_step_err;
  logic [ERR_CNT_W-1:0] err_count;

  typedef struct {
    int bin;
    int inc;
    int dec;
    int err;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   m_have = 0;
  int   m_prev = 0;
  int   m_cnt = 0;

  gray_binary_stream #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
    .out_inc(out_inc), .out_dec(out_dec), .out_step_err(out_step_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int gray_to_bin(input int g);
    for (int b = 0; b < (1 << WIDTH); b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  // Scoreboard: pop on consume, then model and push on accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_have = 0;
      m_prev = 0;
      m_cnt  = 0;
    end else begin
      if (out_valid && out_ready) begin
        check_eq("out_pending", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check_eq("sb_bin", int'(out_bin), e.bin);
          check_eq("sb_inc", int'(out_inc), e.inc);
          check_eq("sb_dec", int'(out_dec), e.dec);
          check_eq("sb_err", int'(out_step_err), e.err);
          check_eq("sb_cnt", int'(err_count), e.cnt);
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        int   d;
        e.bin = gray_to_bin(int'(in_gray));
        d = (e.bin - m_prev + (1 << WIDTH)) % (1 << WIDTH);
        e.inc = (m_have != 0 && d == 1) ? 1 : 0;
        e.dec = (m_have != 0 && d == (1 << WIDTH) - 1) ? 1 : 0;
        e.err = (m_have != 0 && d != 0 && e.inc == 0 && e.dec == 0) ? 1 : 0;
        if (e.err != 0 && m_cnt < 255) m_cnt++;
        e.cnt  = m_cnt;
        m_have = 1;
        m_prev = e.bin;
        q.push_back(e);
        check_eq("sb_depth", q.size(), 1);
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] g);
    in_valid = 1'b1;
    in_gray  = g;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_valid"}, int'(out_valid), 0);
    check_eq({tag, "_bin"}, int'(out_bin), 0);
    check_eq({tag, "_flags"}, int'({out_inc, out_dec, out_step_err}), 0);
    check_eq({tag, "_cnt"}, int'(err_count), 0);
    check_eq({tag, "_ready"}, int'(in_ready), 1);
  endtask

  task automatic reset_pulse();
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero_outputs("rst_async");
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] up_gray [5];
    up_gray = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110};

    // Reset state before any clock edge.
    #2 check_zero_outputs("rst_init");
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Up-stream, back-to-back.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(up_gray[i]);
      check_eq("up_valid", int'(out_valid), 1);
      check_eq("up_bin", int'(out_bin), i);
      check_eq("up_inc", int'(out_inc), (i == 0) ? 0 : 1);
      check_eq("up_err", int'(out_step_err), 0);
    end
    idle(2);

    // Down and wrap.
    reset_pulse();
    send(3'b000);
    send(3'b100);
    check_eq("wrap_bin7", int'(out_bin), 7);
    check_eq("wrap_dec", int'(out_dec), 1);
    send(3'b000);
    check_eq("wrap_bin0", int'(out_bin), 0);
    check_eq("wrap_inc", int'(out_inc), 1);
    check_eq("wrap_cnt", int'(err_count), 0);
    idle(2);

    // Jumps and counter saturation.
    reset_pulse();
    send(3'b011);
    send(3'b111);
    check_eq("jump_bin", int'(out_bin), 5);
    check_eq("jump_err", int'(out_step_err), 1);
    check_eq("jump_cnt", int'(err_count), 1);
    for (int i = 0; i < 256; i++) begin
      send(3'b011);
      send(3'b111);
    end
    check_eq("sat_cnt", int'(err_count), 255);
    idle(2);
    check_eq("sat_hold", int'(err_count), 255);

    // Backpressure, then simultaneous consume and accept.
    reset_pulse();
    out_ready = 1'b0;
    send(3'b010);
    check_eq("bp_valid", int'(out_valid), 1);
    check_eq("bp_ready", int'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      in_gray = WIDTH'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      check_eq("bp_hold_ready", int'(in_ready), 0);
      check_eq("bp_hold_bin", int'(out_bin), 3);
      check_eq("bp_hold_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    send(3'b110);
    check_eq("bp_next_valid", int'(out_valid), 1);
    check_eq("bp_next_bin", int'(out_bin), 4);
    check_eq("bp_next_inc", int'(out_inc), 1);
    in_valid = 1'b0;

    // Reset mid-stream with out_bin=4 pending.
    out_ready = 1'b0;
    reset_pulse();
    out_ready = 1'b1;
    send(3'b111);
    check_eq("mid_bin", int'(out_bin), 5);
    check_eq("mid_inc", int'(out_inc), 0);
    check_eq("mid_err", int'(out_step_err), 0);
    check_eq("mid_cnt", int'(err_count), 0);
    idle(3);
    check_eq("drain_queue", q.size(), 0);
    check_eq("drain_valid", int'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
